uart_recv: RTL and testbench
============================

Name: uart_recv

Overview:
UART 8N1 receiver: the receive-side partner of the team's uart_send transmitter (same 8N1 framing, LSB first, idle-high line, 9600 baud from the 100 MHz board clock).
- Synchronises the asynchronous serial line and detects the start bit.
- Samples each bit at mid-bit, checks the stop bit, presents the byte with a 1-cycle valid pulse.
- Sits between the board RX pin and downstream consumers (display/echo logic); loopback against uart_send is the primary system test.

Parameters:
CNT_MAX, 10415, baud counter terminal value; one bit time = CNT_MAX+1 = 10416 clk cycles (100 MHz / 9600).
HALF_CNT, 5207, mid-bit terminal value used during start-bit validation, equal to (CNT_MAX+1)/2 - 1.

Ports:
clk  input  1  system clock, 100 MHz.
rst  input  1  asynchronous, active-high reset.
din  input  1  serial RX line; asynchronous to clk, idle high.
data  output  8  last correctly received byte; holds until the next good frame.
valid  output  1  1-cycle pulse when data is updated.
frame_err  output  1  1-cycle pulse when the stop bit is sampled low.
busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (rst=1): state=IDLE, data=8'h00, valid=0, frame_err=0, busy=0, both sync flops=1, baud_cnt=0, bit_cnt=0, shift register=0. Reset takes effect at any time; a frame in progress is discarded with no valid or frame_err pulse.
- Input sync: din passes through two flops to give din_s. Only din_s is used internally. This adds 2 cycles of latency.
- baud_cnt (16 bit):
  - Held at 0 in IDLE and WAIT_HIGH.
  - Otherwise increments every cycle.
  - Clears on reaching its terminal value: HALF_CNT in START, CNT_MAX in DATA/STOP.
  - Also clears on every state change.
- State machine (IDLE, START, DATA, STOP, WAIT_HIGH):
  - IDLE: din_s==0 -> START.
  - START: at baud_cnt==HALF_CNT, sample din_s. If 0 -> DATA with bit_cnt=0. If 1 (glitch) -> IDLE, with no outputs asserted.
  - DATA: at baud_cnt==CNT_MAX, shift in din_s. Bit i is stored to shift[i] (LSB first) and bit_cnt increments. The sample taken with bit_cnt==7 moves to STOP. Samples land one full bit time after the mid-start point, i.e. at mid-bit.
  - STOP: at baud_cnt==CNT_MAX, sample din_s.
    - If 1: data<=shift and valid=1 for exactly one cycle, then IDLE.
    - If 0: frame_err=1 for one cycle, data is unchanged, then WAIT_HIGH.
  - WAIT_HIGH: stay until din_s==1, then IDLE. This prevents a break or stuck-low line from retriggering.
  - Illegal or default state -> IDLE.
- Back-to-back frames: returning to IDLE at mid-stop-bit allows a start edge immediately after the stop bit to be caught, so no idle gap is required between frames.
- Latency: valid rises 9*10416 + 5208 + 2 = 98954 cycles after the falling edge of din at the start bit, ±1 cycle.
- valid and frame_err are mutually exclusive and never high in consecutive cycles from the same frame.

Decomposition:
- Shared package uart_pkg:
  - State localparams: IDLE, START, DATA, STOP, WAIT_HIGH, 3-bit encoding.
  - CNT_MAX=10415 and HALF_CNT=5207.
  - uart_send is to be migrated onto the same constants.
- One sub-module: uart_sync2, a 2-flop synchroniser with reset value 1 (reusable for other async pins).
- The baud counter and FSM stay inline.

Test Plan:
- Bench task drives 8N1 at 10416 cycles/bit with byte 8'h55 -> exactly one valid pulse, data=8'h55, frame_err never high, busy low afterwards.
- Drive 8'hA5, then 8'h00 and 8'hFF back-to-back with zero idle between stop and next start -> three valid pulses with data A5, 00, FF in order; spacing between pulses = 10*10416 cycles ±1.
- din low for 3000 cycles then high (glitch shorter than half a bit) -> state returns to IDLE, no valid, no frame_err, data unchanged.
- Frame 8'h3C with stop bit driven 0, line held low 30000 cycles, then high, then good frame 8'h81:
  - frame_err pulses once and data stays at its previous value.
  - No activity while the line is low.
  - Then valid with data=8'h81.
- Assert rst for 5 cycles mid-frame (after bit 3), release, then send 8'h7E:
  - Outputs show reset values during reset.
  - The partial frame produces no pulse.
  - The next frame gives valid with data=8'h7E.
- Loopback: uart_send.dout drives uart_recv.din; send 8'h00, 8'h5A, 8'hC3, 8'hFF via valid pulses -> identical bytes received in order, zero frame_err.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants and state encoding, used by uart_recv and (after migration) uart_send.
package uart_pkg;

    // 100 MHz / 9600 baud = 10416 clocks per bit
    localparam int CNT_MAX  = 10415;
    localparam int HALF_CNT = (CNT_MAX + 1) / 2 - 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous, idle-high input pin.
module uart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/uart_recv.sv
// UART 8N1 receiver: mid-bit sampling, stop-bit check, one-cycle valid / frame_err pulses.
module uart_recv
    import uart_pkg::*;
#(
    parameter int CNT_MAX  = uart_pkg::CNT_MAX,
    parameter int HALF_CNT = uart_pkg::HALF_CNT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    uart_state_t r_state;
    uart_state_t w_next;

    logic        w_din_s;
    logic [15:0] r_baud;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_ferr;
    logic        w_half_hit;
    logic        w_full_hit;
    logic        w_baud_wrap;

    uart_sync2 u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (din),
        .o_sync  (w_din_s)
    );

    assign w_half_hit  = (r_baud == 16'(HALF_CNT));
    assign w_full_hit  = (r_baud == 16'(CNT_MAX));
    assign w_baud_wrap = ((r_state == START) && w_half_hit) ||
                         (((r_state == DATA) || (r_state == STOP)) && w_full_hit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (!w_din_s) w_next = START;
            // a start bit that is gone by mid-bit is treated as a glitch
            START:     if (w_half_hit) w_next = w_din_s ? IDLE : DATA;
            DATA:      if (w_full_hit && (r_bit_cnt == 3'd7)) w_next = STOP;
            // leaving at mid-stop lets a start edge right after the stop bit be caught
            STOP:      if (w_full_hit) w_next = w_din_s ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (w_din_s) w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_baud <= 16'd0;
        end else if ((r_state == IDLE) || (r_state == WAIT_HIGH) ||
                     (w_next != r_state) || w_baud_wrap) begin
            r_baud <= 16'd0;
        end else begin
            r_baud <= r_baud + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            r_data    <= 8'h00;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            if (r_state == START) begin
                r_bit_cnt <= 3'd0;
            end else if ((r_state == DATA) && w_full_hit) begin
                r_shift[r_bit_cnt] <= w_din_s;
                r_bit_cnt          <= r_bit_cnt + 3'd1;
            end else if ((r_state == STOP) && w_full_hit) begin
                if (w_din_s) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_ferr <= 1'b1;
                end
            end
        end
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_ferr;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_recv.sv
// Scoreboard bench for uart_recv, run with a shortened bit time.
module tb_uart_recv;

    localparam int BIT  = 32;
    localparam int CMAX = BIT - 1;
    localparam int HALF = BIT / 2 - 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          vcnt  = 0;
    int          fcnt  = 0;
    logic [7:0]  exp_q[$];
    int          vcyc[$];
    logic [7:0]  exp_data = 8'h00;

    uart_recv #(.CNT_MAX(CMAX), .HALF_CNT(HALF)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // output monitor: pops the scoreboard on every valid pulse
    always @(negedge clk) begin
        if (valid && frame_err) chk("valid_and_ferr", 1, 0);
        if (valid) begin
            vcnt++;
            vcyc.push_back(cyc);
            if (exp_q.size() == 0) chk("unexpected_valid", {24'h0, data}, 32'hFFFF_FFFF);
            else chk("rx_data", {24'h0, data}, {24'h0, exp_q.pop_front()});
        end
        if (frame_err) fcnt++;
    end

    task automatic send_bit(input logic b);
        din = b;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        if (stop_bit) exp_q.push_back(b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_bit);
    endtask

    task automatic wait_vcnt(input int target);
        int budget;
        budget = 12 * BIT;
        while (vcnt < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("wait_valid", vcnt, target);
    endtask

    initial begin
        int n;
        int d;
        int v0;
        int f0;
        logic [7:0] lb[4];

        repeat (3) @(negedge clk);
        chk("rst_data", {24'h0, data}, 32'h0);
        chk("rst_valid", valid, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // single frame
        send_byte(8'h55, 1'b1);
        wait_vcnt(1);
        exp_data = 8'h55;
        repeat (4) @(negedge clk);
        chk("busy_after_55", busy, 0);
        chk("data_55", {24'h0, data}, 32'h55);

        // three back-to-back frames, no idle gap
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        wait_vcnt(4);
        exp_data = 8'hFF;
        n = vcyc.size();
        d = vcyc[n-2] - vcyc[n-3];
        chk("spacing_1", (d >= 10*BIT-1 && d <= 10*BIT+1), 1);
        d = vcyc[n-1] - vcyc[n-2];
        chk("spacing_2", (d >= 10*BIT-1 && d <= 10*BIT+1), 1);
        repeat (2*BIT) @(negedge clk);

        // start glitch shorter than half a bit
        v0 = vcnt;
        f0 = fcnt;
        din = 1'b0;
        repeat (6) @(negedge clk);
        chk("busy_glitch", busy, 1);
        repeat (6) @(negedge clk);
        din = 1'b1;
        repeat (3*BIT) @(negedge clk);
        chk("glitch_no_valid", vcnt, v0);
        chk("glitch_no_ferr", fcnt, f0);
        chk("glitch_idle", busy, 0);
        chk("glitch_data", {24'h0, data}, {24'h0, exp_data});

        // bad stop bit, line held low, then recovery
        send_byte(8'h3C, 1'b0);
        din = 1'b0;
        repeat (3*BIT) @(negedge clk);
        chk("ferr_once", fcnt, f0 + 1);
        chk("ferr_data_held", {24'h0, data}, {24'h0, exp_data});
        chk("low_no_valid", vcnt, v0);
        chk("busy_wait_high", busy, 1);
        din = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_after_high", busy, 0);
        chk("ferr_stays_once", fcnt, f0 + 1);
        send_byte(8'h81, 1'b1);
        wait_vcnt(v0 + 1);
        exp_data = 8'h81;

        // reset in the middle of a frame
        v0 = vcnt;
        f0 = fcnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0 ^ ((8'h7E >> i) & 1));
        din = 1'b1;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("midrst_data", {24'h0, data}, 32'h0);
        chk("midrst_valid", valid, 0);
        chk("midrst_ferr", frame_err, 0);
        chk("midrst_busy", busy, 0);
        rst = 1'b0;
        repeat (2*BIT) @(negedge clk);
        chk("partial_no_valid", vcnt, v0);
        chk("partial_no_ferr", fcnt, f0);
        send_byte(8'h7E, 1'b1);
        wait_vcnt(v0 + 1);

        // transmitter-style loopback burst
        lb[0] = 8'h00; lb[1] = 8'h5A; lb[2] = 8'hC3; lb[3] = 8'hFF;
        v0 = vcnt;
        for (int i = 0; i < 4; i++) send_byte(lb[i], 1'b1);
        wait_vcnt(v0 + 4);
        chk("loop_no_ferr", fcnt, f0);

        repeat (BIT) @(negedge clk);
        chk("ferr_total", fcnt, 1);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20_000_000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1);
    end

endmodule
